// File: rtl/csr_req_arbiter_if.sv
// Bundles the two requester ports, their response ports and the shared CSR bus.
// The slave modport is the arbiter's view; the master modport is the requester/bus side.
interface csr_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [1:0]            req0_op;
    logic [2:0]            req0_funct3;
    logic [4:0]            req0_imm;
    logic [REG_WIDTH-1:0]  req0_rs1_val;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  rsp0_valid;
    logic [ADDR_WIDTH-1:0] rsp0_rdata;
    logic                  rsp0_err;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [1:0]            req1_op;
    logic [2:0]            req1_funct3;
    logic [4:0]            req1_imm;
    logic [REG_WIDTH-1:0]  req1_rs1_val;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  rsp1_valid;
    logic [ADDR_WIDTH-1:0] rsp1_rdata;
    logic                  rsp1_err;

    logic [1:0]            bus_csr_op;
    logic [2:0]            bus_csr_funct3;
    logic [4:0]            bus_csr_imm;
    logic [REG_WIDTH-1:0]  bus_rs1_val;
    logic [ADDR_WIDTH-1:0] bus_csr_addr;
    logic                  bus_csr_valid;
    logic                  bus_csr_rrsp;
    logic [ADDR_WIDTH-1:0] bus_csr_rdata;
    logic                  bus_csr_rvalid;
    logic                  bus_csr_reg_rsp;
    logic                  busy;

    modport slave (
        input  req0_valid, req0_op, req0_funct3, req0_imm, req0_rs1_val, req0_addr,
        input  req1_valid, req1_op, req1_funct3, req1_imm, req1_rs1_val, req1_addr,
        input  bus_csr_rdata, bus_csr_rvalid, bus_csr_reg_rsp,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output bus_csr_op, bus_csr_funct3, bus_csr_imm, bus_rs1_val, bus_csr_addr,
        output bus_csr_valid, bus_csr_rrsp, busy
    );

    modport master (
        output req0_valid, req0_op, req0_funct3, req0_imm, req0_rs1_val, req0_addr,
        output req1_valid, req1_op, req1_funct3, req1_imm, req1_rs1_val, req1_addr,
        output bus_csr_rdata, bus_csr_rvalid, bus_csr_reg_rsp,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  bus_csr_op, bus_csr_funct3, bus_csr_imm, bus_rs1_val, bus_csr_addr,
        input  bus_csr_valid, bus_csr_rrsp, busy
    );
endinterface

// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter sharing one CSR bus between core (req0) and debug (req1), one transaction in flight.
// Latency: accept->RESP is 1 cycle (illegal op), 2 (write / same-cycle read), up to TIMEOUT_CYCLES+2 (read); requesters held via ready while busy.
module csr_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_req_arbiter_if.slave    bus_if
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_gnt;
    logic [1:0]            r_op;
    logic [2:0]            r_funct3;
    logic [4:0]            r_imm;
    logic [REG_WIDTH-1:0]  r_rs1;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [TW-1:0]         r_timer;

    logic                  w_take;
    logic                  w_win1;
    logic [1:0]            w_op;
    logic [2:0]            w_funct3;
    logic [4:0]            w_imm;
    logic [REG_WIDTH-1:0]  w_rs1;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_bus_act;

    // On a tie the requester that did not win last time gets the bus.
    assign w_win1 = bus_if.req1_valid && (!bus_if.req0_valid || !r_last_grant);
    assign w_take = (r_state == S_IDLE) && (bus_if.req0_valid || bus_if.req1_valid);

    assign w_op     = w_win1 ? bus_if.req1_op      : bus_if.req0_op;
    assign w_funct3 = w_win1 ? bus_if.req1_funct3  : bus_if.req0_funct3;
    assign w_imm    = w_win1 ? bus_if.req1_imm     : bus_if.req0_imm;
    assign w_rs1    = w_win1 ? bus_if.req1_rs1_val : bus_if.req0_rs1_val;
    assign w_addr   = w_win1 ? bus_if.req1_addr    : bus_if.req0_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_op         <= '0;
            r_funct3     <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_addr       <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_gnt        <= w_win1;
                        r_last_grant <= w_win1;
                        r_op         <= w_op;
                        r_funct3     <= w_funct3;
                        r_imm        <= w_imm;
                        r_rs1        <= w_rs1;
                        r_addr       <= w_addr;
                        r_timer      <= '0;
                        if (w_op == 2'b00) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_op[1]) begin
                        if (bus_if.bus_csr_rvalid) begin
                            r_rdata <= bus_if.bus_csr_rdata;
                            r_err   <= bus_if.bus_csr_reg_rsp;
                            r_state <= S_RESP;
                        end else begin
                            r_timer <= '0;
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_rdata <= '0;
                        r_err   <= bus_if.bus_csr_reg_rsp;
                        r_state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    // A late rvalid on the final timer cycle still completes the read.
                    if (bus_if.bus_csr_rvalid) begin
                        r_rdata <= bus_if.bus_csr_rdata;
                        r_err   <= bus_if.bus_csr_reg_rsp;
                        r_state <= S_RESP;
                    end else if (r_timer == TIMER_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_bus_act = (r_state == S_ISSUE) || (r_state == S_WAIT);

    assign bus_if.req0_ready = w_take && !w_win1;
    assign bus_if.req1_ready = w_take &&  w_win1;

    assign bus_if.bus_csr_valid  = (r_state == S_ISSUE);
    assign bus_if.bus_csr_rrsp   = w_bus_act && r_op[1] && bus_if.bus_csr_rvalid;
    assign bus_if.bus_csr_op     = w_bus_act ? r_op     : '0;
    assign bus_if.bus_csr_funct3 = w_bus_act ? r_funct3 : '0;
    assign bus_if.bus_csr_imm    = w_bus_act ? r_imm    : '0;
    assign bus_if.bus_rs1_val    = w_bus_act ? r_rs1    : '0;
    assign bus_if.bus_csr_addr   = w_bus_act ? r_addr   : '0;

    assign bus_if.rsp0_valid = (r_state == S_RESP) && !r_gnt;
    assign bus_if.rsp1_valid = (r_state == S_RESP) &&  r_gnt;
    assign bus_if.rsp0_rdata = bus_if.rsp0_valid ? r_rdata : '0;
    assign bus_if.rsp1_rdata = bus_if.rsp1_valid ? r_rdata : '0;
    assign bus_if.rsp0_err   = bus_if.rsp0_valid && r_err;
    assign bus_if.rsp1_err   = bus_if.rsp1_valid && r_err;

    assign bus_if.busy = (r_state != S_IDLE);
endmodule
